// File: rtl/mudi_unit_if.sv
// rtl/mudi_unit_if.sv - E-stage control, operand and result bundle of the mult/div unit
interface mudi_unit_if;
    logic [2:0]  E_mudiOp;
    logic        E_isStart;
    logic        E_MUDI_sel;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        req;
    logic        busy;
    logic [31:0] E_mudiOut;

    modport master (
        output E_mudiOp, E_isStart, E_MUDI_sel, E_rs, E_rt, req,
        input  busy, E_mudiOut
    );

    modport slave (
        input  E_mudiOp, E_isStart, E_MUDI_sel, E_rs, E_rt, req,
        output busy, E_mudiOut
    );
endinterface

// File: rtl/mudi_unit.sv
// rtl/mudi_unit.sv - HI/LO multiply/divide unit with busy counter; MUDI_ZERO_LATENCY_EN commits mult/div at accept
module mudi_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mudi_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} stateType;

    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    stateType    state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [31:0] hi, lo;
    logic        accept, isMulDiv, isDiv, isSigned, divZero;
    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag, qMag, rMag, quot, rem;
    logic [63:0] aExt, bExt, product, result;

    assign bus.busy      = (state == RUN);
    assign bus.E_mudiOut = bus.E_MUDI_sel ? hi : lo;

    assign accept   = bus.E_isStart & ~bus.req & ~bus.busy;
    assign isMulDiv = ~bus.E_mudiOp[2];
    assign isDiv    = bus.E_mudiOp[1];
    assign isSigned = ~bus.E_mudiOp[0];
    assign divZero  = isDiv & (bus.E_rt == 32'd0);

    // Signed ops work on magnitudes so INT_MIN / -1 wraps deterministically
    assign aNeg    = isSigned & bus.E_rs[31];
    assign bNeg    = isSigned & bus.E_rt[31];
    assign aMag    = aNeg ? -bus.E_rs : bus.E_rs;
    assign bMag    = bNeg ? -bus.E_rt : bus.E_rt;
    assign qMag    = (bMag == 32'd0) ? 32'd0 : aMag / bMag;
    assign rMag    = (bMag == 32'd0) ? 32'd0 : aMag % bMag;
    assign quot    = (aNeg ^ bNeg) ? -qMag : qMag;
    assign rem     = aNeg ? -rMag : rMag;
    assign aExt    = {{32{aNeg}}, bus.E_rs};
    assign bExt    = {{32{bNeg}}, bus.E_rt};
    assign product = aExt * bExt;
    assign result  = isDiv ? {rem, quot} : product;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
`ifndef MUDI_ZERO_LATENCY_EN
                if (accept && isMulDiv) begin
                    stateNext = RUN;
                    cntNext   = isDiv ? DIV_CNT : MULT_CNT;
                end
`endif
            end
            RUN: begin
                cntNext = cnt - 4'd1;
                if (cnt == 4'd1) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifndef MUDI_ZERO_LATENCY_EN
    logic [63:0] pendRes;
    logic        pendOk;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
`ifndef MUDI_ZERO_LATENCY_EN
            pendRes <= 64'd0;
            pendOk  <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept && bus.E_mudiOp == OP_MTHI) hi <= bus.E_rs;
            if (accept && bus.E_mudiOp == OP_MTLO) lo <= bus.E_rs;
`ifdef MUDI_ZERO_LATENCY_EN
            if (accept && isMulDiv && !divZero) {hi, lo} <= result;
`else
            if (accept && isMulDiv) begin
                pendRes <= result;
                pendOk  <= ~divZero;
            end
            // Accept needs IDLE, so this never collides with the writes above
            if (state == RUN && cnt == 4'd1 && pendOk) {hi, lo} <= pendRes;
`endif
        end
    end
endmodule

// File: tb/tb_mudi_unit.sv
// tb/tb_mudi_unit.sv - self-checking bench for mudi_unit against a completion-time model
module tb_mudi_unit;
`ifdef MUDI_ZERO_LATENCY_EN
    localparam int ML = 0;
    localparam int DL = 0;
`else
    localparam int ML = 5;
    localparam int DL = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mudi_unit_if bus();
    mudi_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic [31:0] mHi, mLo;
    bit          mActive;
    int          mDone;
    logic [63:0] mPend;
    bit          mOk;

    function automatic void modelReset();
        mHi = 0; mLo = 0; mActive = 0; mDone = 0; mPend = 0; mOk = 0;
    endfunction

    function automatic void modelAccept(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        bit ok;
        int lat;
        ok = 1; res = 0; lat = 0;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        case (op)
            3'd0: begin res = sa * sb; lat = ML; end
            3'd1: begin res = ua * ub; lat = ML; end
            3'd2: begin
                lat = DL;
                if (rt == 0) ok = 0;
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            3'd3: begin
                lat = DL;
                if (rt == 0) ok = 0;
                else res = {rs % rt, rs / rt};
            end
            3'd4: mHi = rs;
            3'd5: mLo = rs;
            default: ;
        endcase
        if (op <= 3'd3) begin
            if (lat == 0) begin
                if (ok) {mHi, mLo} = res;
            end else begin
                mActive = 1; mDone = cyc + lat; mPend = res; mOk = ok;
            end
        end
    endfunction

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic rq);
        bus.E_isStart = s; bus.E_mudiOp = op; bus.E_rs = rs; bus.E_rt = rt; bus.req = rq;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic tick();
        bit busyBefore;
        @(posedge clk);
        cyc++;
        if (!reset) modelReset();
        else begin
            busyBefore = mActive;
            if (mActive && cyc == mDone) begin
                if (mOk) {mHi, mLo} = mPend;
                mActive = 0;
            end
            if (bus.E_isStart && !bus.req && !busyBefore) modelAccept(bus.E_mudiOp, bus.E_rs, bus.E_rt);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); bus.E_MUDI_sel = 1'b1; modelReset();
        #3;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.E_mudiOut !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.E_mudiOut); end
        tick(); tick();
        reset = 1'b1;
        drive(1'b1, 3'd0, 32'h1234_5678, 32'h9abc_def1, 1'b0);
        tick(); idle(); tick(); tick();
        #2;
        reset = 1'b0; modelReset();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %0b want 0", bus.busy); end
        bus.E_MUDI_sel = 1'b1; #1;
        checks++; if (bus.E_mudiOut !== 32'd0) begin errors++; $display("FAIL midrun_reset_hi got %h want 0", bus.E_mudiOut); end
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== 32'd0) begin errors++; $display("FAIL midrun_reset_lo got %h want 0", bus.E_mudiOut); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < DL + 2; i++) tick();
        checks++; if (bus.E_mudiOut !== 32'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mflo_after_reset got %h busy %0b want 0", bus.E_mudiOut, bus.busy);
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input logic [31:0] wantHi, input logic [31:0] wantLo);
        int n;
        drive(1'b1, op, rs, rt, 1'b0);
        tick(); idle();
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        checks++; if (n !== lat) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, n, lat); end
        bus.E_MUDI_sel = 1'b1; #1;
        checks++; if (bus.E_mudiOut !== wantHi) begin errors++; $display("FAIL %s_hi got %h want %h", name, bus.E_mudiOut, wantHi); end
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== wantLo) begin errors++; $display("FAIL %s_lo got %h want %h", name, bus.E_mudiOut, wantLo); end
    endtask

    task automatic test_mult();
        runOp("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, ML, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, ML, 32'h0000_0002, 32'hFFFF_FFFA);
        runOp("mult_big", 3'd0, 32'h0001_0000, 32'h0001_0000, ML, 32'h0000_0001, 32'h0000_0000);
    endtask

    task automatic test_div();
        runOp("div",   3'd2, 32'hFFFF_FFF9, 32'd2, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu0", 3'd3, 32'd7, 32'd0, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    endtask

    task automatic test_suppress();
        int n;
        drive(1'b1, 3'd5, 32'h0000_1234, 32'd0, 1'b1);
        tick(); idle();
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== 32'hFFFF_FFFD || bus.busy !== 1'b0) begin
            errors++; $display("FAIL req_mtlo got %h busy %0b want fffffffd busy 0", bus.E_mudiOut, bus.busy);
        end
        drive(1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
        tick();
        drive(1'b1, 3'd4, 32'h0000_0055, 32'd0, 1'b0); tick();
        drive(1'b1, 3'd2, 32'd100, 32'd3, 1'b0); tick();
        idle();
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        bus.E_MUDI_sel = 1'b1; #1;
        checks++; if (bus.E_mudiOut !== 32'd0) begin errors++; $display("FAIL start_in_run_hi got %h want 0", bus.E_mudiOut); end
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== 32'd42) begin errors++; $display("FAIL start_in_run_lo got %h want 2a", bus.E_mudiOut); end
    endtask

    task automatic test_mthi();
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        tick(); idle();
        bus.E_MUDI_sel = 1'b1; #1;
        checks++; if (bus.E_mudiOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi got %h want deadbeef", bus.E_mudiOut); end
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== 32'd42) begin errors++; $display("FAIL mthi_old_lo got %h want 2a", bus.E_mudiOut); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
        tick(); idle();
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        tick(); idle();
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.busy !== (DL != 0)) begin errors++; $display("FAIL b2b_busy got %0b want %0b", bus.busy, DL != 0); end
        checks++; if (bus.E_mudiOut !== ((DL != 0) ? 32'd12 : 32'd14)) begin
            errors++; $display("FAIL b2b_lo_during got %h want %h", bus.E_mudiOut, (DL != 0) ? 32'd12 : 32'd14);
        end
        n = 0;
        while (bus.busy && n < 40) begin n++; tick(); end
        bus.E_MUDI_sel = 1'b1; #1;
        checks++; if (bus.E_mudiOut !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h want 2", bus.E_mudiOut); end
        bus.E_MUDI_sel = 1'b0; #1;
        checks++; if (bus.E_mudiOut !== 32'd14) begin errors++; $display("FAIL b2b_lo got %h want e", bus.E_mudiOut); end
    endtask

    task automatic test_random();
        logic [31:0] rs, rt, want;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) - 32'd10 : $urandom;
            rt = ($urandom_range(7) == 0) ? 32'd0 : (($urandom_range(2) == 0) ? 32'($urandom_range(9)) - 32'd4 : $urandom);
            drive($urandom_range(2) == 0, 3'($urandom_range(7)), rs, rt, $urandom_range(7) == 0);
            bus.E_MUDI_sel = 1'($urandom_range(1));
            #1;
            want = bus.E_MUDI_sel ? mHi : mLo;
            checks++; if (bus.busy !== mActive) begin errors++; $display("FAIL rand_busy cyc %0d got %0b want %0b", cyc, bus.busy, mActive); end
            checks++; if (bus.E_mudiOut !== want) begin errors++; $display("FAIL rand_out cyc %0d got %h want %h", cyc, bus.E_mudiOut, want); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_suppress();
        test_mthi();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
